// File: rtl/multi_port_bus_arbiter_if.sv
// multi_port_bus_arbiter_if: signal bundle between the requesters, the arbiter and the external bus.
// Parameters match the arbiter: NUM_PORTS, BUS_ADDRESS_WIDTH, BUS_DATA_WIDTH_SHIFT.
// slave modport (arbiter side):
//   in : req_addr_i[NUM_PORTS*AW], req_data_i[NUM_PORTS*DW], req_we_i, req_valid_i, req_urgent_i, bus_valid_i
//   out: req_valid_o (completion pulses), bus_addr_o, bus_data_o, bus_we_o, bus_valid_o, grant_idx_o, busy_o
// master modport: the same signals seen from the requester/bus side.
interface multi_port_bus_arbiter_if #(
  parameter int NUM_PORTS            = 2,
  parameter int BUS_ADDRESS_WIDTH    = 20,
  parameter int BUS_DATA_WIDTH_SHIFT = 4
);
  localparam int DW = 8 << BUS_DATA_WIDTH_SHIFT;
  localparam int AW = BUS_ADDRESS_WIDTH - BUS_DATA_WIDTH_SHIFT;
  localparam int IW = NUM_PORTS > 2 ? $clog2(NUM_PORTS) : 1;
  logic [NUM_PORTS*AW-1:0] req_addr_i;
  logic [NUM_PORTS*DW-1:0] req_data_i;
  logic [NUM_PORTS-1:0]    req_we_i;
  logic [NUM_PORTS-1:0]    req_valid_i;
  logic [NUM_PORTS-1:0]    req_urgent_i;
  logic [NUM_PORTS-1:0]    req_valid_o;
  logic [AW-1:0]           bus_addr_o;
  logic [DW-1:0]           bus_data_o;
  logic                    bus_we_o;
  logic                    bus_valid_o;
  logic                    bus_valid_i;
  logic [IW-1:0]           grant_idx_o;
  logic                    busy_o;
  modport slave (
    input  req_addr_i, req_data_i, req_we_i, req_valid_i, req_urgent_i, bus_valid_i,
    output req_valid_o, bus_addr_o, bus_data_o, bus_we_o, bus_valid_o, grant_idx_o, busy_o
  );
  modport master (
    output req_addr_i, req_data_i, req_we_i, req_valid_i, req_urgent_i, bus_valid_i,
    input  req_valid_o, bus_addr_o, bus_data_o, bus_we_o, bus_valid_o, grant_idx_o, busy_o
  );
endinterface

// File: rtl/multi_port_bus_arbiter.sv
// multi_port_bus_arbiter: N-port arbiter sharing one memory bus, urgent class first, grant held until bus completion.
// Ports: clk_i, rst_i (sync, active-high); bus = multi_port_bus_arbiter_if.slave (requester inputs, bus outputs,
//   per-port completion pulses, grant_idx_o, busy_o).
// Macro ARB_ROUND_ROBIN_EN: defined gives rotating priority starting after the last grant;
//   undefined gives fixed priority (lowest index wins) and no last-grant register.
module multi_port_bus_arbiter #(
  parameter int NUM_PORTS            = 2,
  parameter int BUS_ADDRESS_WIDTH    = 20,
  parameter int BUS_DATA_WIDTH_SHIFT = 4
) (
  input logic clk_i,
  input logic rst_i,
  multi_port_bus_arbiter_if.slave bus
);
  localparam int DW = 8 << BUS_DATA_WIDTH_SHIFT;
  localparam int AW = BUS_ADDRESS_WIDTH - BUS_DATA_WIDTH_SHIFT;
  localparam int IW = NUM_PORTS > 2 ? $clog2(NUM_PORTS) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, win;
  logic [NUM_PORTS-1:0] urg, cand;
  logic busy, start;
  assign urg   = bus.req_valid_i & bus.req_urgent_i;
  assign cand  = |urg ? urg : bus.req_valid_i;
  assign start = state_q == IDLE && |bus.req_valid_i;
`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0] last_q, win_hi;
  logic hi;
  // Rotating scan: lowest candidate above last_q wins, otherwise wrap to lowest candidate overall.
  always_comb begin
    win    = '0;
    win_hi = '0;
    hi     = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (cand[i]) win = IW'(i);
      if (cand[i] && i > int'(last_q)) begin
        win_hi = IW'(i);
        hi     = 1'b1;
      end
    end
    win = hi ? win_hi : win;
  end
  always_ff @(posedge clk_i)
    last_q <= rst_i ? IW'(NUM_PORTS - 1) : start ? win : last_q;
`else
  always_comb begin
    win = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if (cand[i]) win = IW'(i);
  end
`endif
  always_comb begin
    state_d = state_q == IDLE ? (start ? BUSY : IDLE) : (bus.bus_valid_i ? IDLE : BUSY);
    grant_d = start ? win : grant_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end
  assign busy            = state_q == BUSY;
  assign bus.busy_o      = busy;
  assign bus.bus_valid_o = busy;
  assign bus.grant_idx_o = grant_q;
  assign bus.bus_addr_o  = busy ? bus.req_addr_i[int'(grant_q)*AW +: AW] : '0;
  assign bus.bus_data_o  = busy ? bus.req_data_i[int'(grant_q)*DW +: DW] : '0;
  assign bus.bus_we_o    = busy & bus.req_we_i[grant_q];
  assign bus.req_valid_o = (busy && bus.bus_valid_i) ? (NUM_PORTS'(1) << grant_q) : '0;
endmodule
